// File: rtl/inv_round_tf.sv
// ---------------------------------------------------------------------------
// inv_round_tf -- multi-cycle AES inverse round transform.
//
// Undoes one encryption round in this order:
//   AddRoundKey -> InvMixColumns (can be skipped) -> InvShiftRows -> InvSubBytes
// InvMixColumns handles one column per cycle using a single column slice.
// InvSubBytes uses four shared inverse S-boxes and also handles one column
// per cycle.
//
// Optional build macro: INV_ROUND_TF_FAST_EN
//   When this macro is defined, the design uses sixteen inverse S-boxes and
//   InvSubBytes completes in a single cycle. Everything else is unchanged.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start_i     accept a new job; sampled only in IDLE
//   skip_imc_i  bypass InvMixColumns; sampled together with start_i
//   s_i         128-bit input state; sampled together with start_i
//   k_i         128-bit round key; sampled together with start_i
//   s_isr_o     state after InvShiftRows (registered debug tap)
//   s_o         final result; registered and held until the next completion
//   busy_o      high from the cycle after acceptance through the done cycle
//   done_o      one-cycle completion pulse
//
// Byte b of a state is s[127-8b -: 8]. Column c holds bytes 4c..4c+3.
// ---------------------------------------------------------------------------
module inv_round_tf (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         skip_imc_i,
    input  logic [127:0] s_i,
    input  logic [127:0] k_i,
    output logic [127:0] s_isr_o,
    output logic [127:0] s_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] IMC  = 3'd1;
    localparam logic [2:0] ISR  = 3'd2;
    localparam logic [2:0] ISB  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    // ---------------- GF(2^8) arithmetic, poly 0x11B ----------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (the product of x^2, x^4, ..., x^128).
    // An input of 0 maps to 0, as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse S-box: first undo the affine map, then take the field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
        return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Row r rotates right by r: each output byte (c, r) takes input byte (c-r mod 4, r).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // ---------------- state ----------------
    logic [2:0]       state;
    logic [1:0]       col;
    logic             skip_q;
    logic [3:0][31:0] st;       // st[3] holds column 0, st[0] holds column 3

    logic [1:0]   col_idx;
    logic [31:0]  imc_col;
    logic [127:0] isr_state;

    assign col_idx   = 2'd3 - col;   // maps column number to packed slot
    assign imc_col   = inv_mix_col(st[col_idx]);
    assign isr_state = inv_shift_rows(st);

`ifdef INV_ROUND_TF_FAST_EN
    logic [127:0] isb_all;
    assign isb_all = {inv_sub_word(st[3]), inv_sub_word(st[2]),
                      inv_sub_word(st[1]), inv_sub_word(st[0])};
`else
    logic [31:0] isb_col;
    assign isb_col = inv_sub_word(st[col_idx]);
`endif

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // reads of st, col and state returning their pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the working state st is cleared on reset as well. This
            // ensures an aborted job leaves nothing behind.
            state   <= IDLE;
            col     <= 2'd0;
            skip_q  <= 1'b0;
            st      <= '0;
            s_o     <= '0;
            s_isr_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        st     <= s_i ^ k_i;
                        skip_q <= skip_imc_i;
                        col    <= 2'd0;
                        busy_o <= 1'b1;
                        state  <= skip_imc_i ? ISR : IMC;
                    end
                end
                IMC: begin
                    st[col_idx] <= imc_col;
                    col         <= col + 2'd1;
                    if (col == 2'd3) state <= ISR;
                end
                ISR: begin
                    st      <= isr_state;
                    s_isr_o <= isr_state;
                    col     <= 2'd0;
                    state   <= ISB;
                end
                ISB: begin
`ifdef INV_ROUND_TF_FAST_EN
                    st     <= isb_all;
                    s_o    <= isb_all;
                    done_o <= 1'b1;
                    state  <= DONE;
`else
                    st[col_idx] <= isb_col;
                    col         <= col + 2'd1;
                    if (col == 2'd3) begin
                        // The last column goes into slot 0. Columns 0..2 are already final.
                        s_o    <= {st[3], st[2], st[1], isb_col};
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
`endif
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_round_tf.sv
// ---------------------------------------------------------------------------
// tb_inv_round_tf -- self-checking bench for inv_round_tf.
// Each job pushes its expected result and latency to a scoreboard queue when
// it is started. The entry is popped and compared when done_o is seen.
// ---------------------------------------------------------------------------
module tb_inv_round_tf;

    localparam logic [127:0] VEC_FULL = 128'h6379e6d9f467fb76ad063cf4d2eb8aa3;
    localparam logic [127:0] VEC_SKIP = 128'h63fcac161bee28c3c4c193f54b8233ea;
    localparam logic [127:0] ISR_EXP  = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] PLAIN    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY      = 128'h000102030405060708090a0b0c0d0e0f;

`ifdef INV_ROUND_TF_FAST_EN
    localparam int LAT_FULL = 6;
    localparam int LAT_SKIP = 2;
`else
    localparam int LAT_FULL = 9;
    localparam int LAT_SKIP = 5;
`endif
    localparam int ISR_FULL = 5;
    localparam int ISR_SKIP = 1;

    typedef struct {
        logic [127:0] so;
        logic [127:0] isr;
        int           lat;
        int           isr_lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         skip_imc_i;
    logic [127:0] s_i;
    logic [127:0] k_i;
    logic [127:0] s_isr_o;
    logic [127:0] s_o;
    logic         busy_o;
    logic         done_o;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    logic [127:0] held_so  = '0;
    exp_t         sb[$];

    inv_round_tf dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .skip_imc_i (skip_imc_i),
        .s_i        (s_i),
        .k_i        (k_i),
        .s_isr_o    (s_isr_o),
        .s_o        (s_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    // done_o lasts exactly one cycle, so each pulse is seen on exactly one falling edge.
    always @(negedge clk) if (done_o === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives start_i for one acceptance edge and records the expectation.
    // If hold is set, start_i stays high after acceptance.
    task automatic start_job(input logic [127:0] s, input logic [127:0] k, input logic skip,
                             input exp_t e, input bit hold);
        s_i        = s;
        k_i        = k;
        skip_imc_i = skip;
        start_i    = 1'b1;
        sb.push_back(e);
        tick();
        start_i    = hold;
        s_i        = rnd128();
        k_i        = rnd128();
        skip_imc_i = ~skip;
        check("busy_after_accept", {127'd0, busy_o}, 128'd1);
    endtask

    // Waits for done_o with a cycle budget, checking s_o hold and the s_isr_o tap on the way.
    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        e = sb[0];
        n = 0;
        while (1) begin
            tick();
            n++;
            if (n == e.isr_lat) check({tag, "_isr_tap"}, s_isr_o, e.isr);
            if (done_o === 1'b1) break;
            check({tag, "_so_hold"}, s_o, held_so);
            if (n >= 40) begin
                n_checks++;
                assert (done_o === 1'b1) else begin
                    n_fail++;
                    $error("FAIL %s_timeout: observed no done_o expected done within 40 cycles", tag);
                end
                break;
            end
        end
        e = sb.pop_front();
        check({tag, "_s_o"}, s_o, e.so);
        check({tag, "_s_isr_o"}, s_isr_o, e.isr);
        check({tag, "_latency"}, 128'(n), 128'(e.lat));
        check({tag, "_busy_in_done"}, {127'd0, busy_o}, 128'd1);
        held_so = e.so;
    endtask

    // The edge that ends DONE: done_o drops and busy_o drops.
    task automatic finish_job(input string tag);
        tick();
        check({tag, "_done_pulse_end"}, {127'd0, done_o}, 128'd0);
        check({tag, "_busy_end"}, {127'd0, busy_o}, 128'd0);
    endtask

    initial begin
        exp_t         e_full;
        exp_t         e_skip;
        int           d0;
        logic [127:0] isr_hold;

        e_full = '{so: PLAIN, isr: ISR_EXP, lat: LAT_FULL, isr_lat: ISR_FULL};
        e_skip = '{so: PLAIN, isr: ISR_EXP, lat: LAT_SKIP, isr_lat: ISR_SKIP};

        rst = 1'b1; start_i = 1'b0; skip_imc_i = 1'b0; s_i = '0; k_i = '0;
        tick();
        tick();
        check("reset_s_o", s_o, 128'd0);
        check("reset_s_isr_o", s_isr_o, 128'd0);
        check("reset_done", {127'd0, done_o}, 128'd0);
        check("reset_busy", {127'd0, busy_o}, 128'd0);
        rst = 1'b0;
        tick();

        // Full round with a zero key.
        start_job(VEC_FULL, 128'd0, 1'b0, e_full, 1'b0);
        wait_done("full");
        finish_job("full");

        // Skip InvMixColumns. Start again at the earliest allowed point.
        start_job(VEC_SKIP, 128'd0, 1'b1, e_skip, 1'b0);
        wait_done("skip");
        finish_job("skip");

        // Apply a non-zero round key.
        start_job(VEC_FULL ^ KEY, KEY, 1'b0, e_full, 1'b0);
        wait_done("key");
        finish_job("key");

        // Hold start_i high for a whole job. A second job must start right after DONE.
        held_so = PLAIN;
        d0 = done_cnt;
        start_job(VEC_FULL, 128'd0, 1'b0, e_full, 1'b1);
        wait_done("busy_start1");
        s_i = VEC_SKIP; k_i = 128'd0; skip_imc_i = 1'b1;
        sb.push_back(e_skip);
        finish_job("busy_start1");
        tick();                          // IDLE with start_i still high: accepted here
        start_i = 1'b0;
        s_i = rnd128(); k_i = rnd128(); skip_imc_i = 1'b0;
        check("busy_start_one_pulse", 128'(done_cnt - d0), 128'd1);
        wait_done("busy_start2");
        finish_job("busy_start2");

        // Reset at cycle N+3 aborts the job.
        d0 = done_cnt;
        start_job(VEC_FULL, 128'd0, 1'b0, e_full, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        held_so = '0;
        check("abort_s_o", s_o, 128'd0);
        check("abort_busy", {127'd0, busy_o}, 128'd0);
        for (int i = 0; i < 15; i++) tick();
        check("abort_no_done", 128'(done_cnt - d0), 128'd0);
        check("abort_busy_later", {127'd0, busy_o}, 128'd0);
        check("abort_s_o_later", s_o, 128'd0);

        // A fresh job after the reset.
        start_job(VEC_FULL ^ KEY, KEY, 1'b0, e_full, 1'b0);
        wait_done("after_reset");
        finish_job("after_reset");

        // Results are held while inputs change without start_i.
        isr_hold = ISR_EXP;
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            s_i = rnd128();
            k_i = rnd128();
            skip_imc_i = i[0];
            tick();
        end
        check("hold_s_o", s_o, held_so);
        check("hold_s_isr_o", s_isr_o, isr_hold);
        check("hold_no_done", 128'(done_cnt - d0), 128'd0);
        check("hold_busy", {127'd0, busy_o}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
